// File: rtl/datapath_executor_pkg.sv
// Shared constants for the instruction dispatch path: field widths and
// positions, opcodes, world-state RAM regions and executor state encoding.
package datapath_executor_pkg;

  localparam int OPCODE_FIELD_W = 4;
  localparam int MEM_ADDR_W     = 8;
  localparam int RESULT_W       = 16;
  localparam int INSTRUCTION_W  = RESULT_W + MEM_ADDR_W + OPCODE_FIELD_W;

  // Field positions inside {data, address, opcode}
  localparam int OPCODE_LSB = 0;
  localparam int ADDR_LSB   = OPCODE_LSB + OPCODE_FIELD_W;
  localparam int DATA_LSB   = ADDR_LSB + MEM_ADDR_W;

  localparam logic [OPCODE_FIELD_W-1:0] OPCODE_NOP      = 4'd0;
  localparam logic [OPCODE_FIELD_W-1:0] OPCODE_MEMWRITE = 4'd1;
  localparam logic [OPCODE_FIELD_W-1:0] OPCODE_MEMREAD  = 4'd2;
  localparam logic [OPCODE_FIELD_W-1:0] OPCODE_MEMADD   = 4'd3;

  // World-state RAM regions (base addresses)
  localparam logic [MEM_ADDR_W-1:0] ADDR_FOOD_X   = 8'h00;
  localparam logic [MEM_ADDR_W-1:0] ADDR_FOOD_Y   = 8'h40;
  localparam logic [MEM_ADDR_W-1:0] ADDR_POISON_X = 8'h80;
  localparam logic [MEM_ADDR_W-1:0] ADDR_POISON_Y = 8'hC0;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WRITE        = 3'd1,
    ST_READ_WAIT    = 3'd2,
    ST_READ_CAPTURE = 3'd3,
    ST_ADD_WRITE    = 3'd4,
    ST_DONE         = 3'd5
  } exec_state_t;

  // Packs an instruction word the way initiators present it
  function automatic logic [INSTRUCTION_W-1:0] pack_instruction(
    input logic [OPCODE_FIELD_W-1:0] opcode,
    input logic [MEM_ADDR_W-1:0]     addr,
    input logic [RESULT_W-1:0]       data
  );
    return {data, addr, opcode};
  endfunction

endpackage

// File: rtl/datapath_executor_instr_field_decode.sv
// Combinational split of an instruction word into opcode/address/data,
// plus a flag telling whether the opcode is one the executor implements.
module instr_field_decode
  import datapath_executor_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16
) (
  input  logic [DATA_WIDTH+ADDR_WIDTH+OPCODE_WIDTH-1:0] i_instruction,
  output logic [OPCODE_WIDTH-1:0]                       o_opcode,
  output logic [ADDR_WIDTH-1:0]                         o_addr,
  output logic [DATA_WIDTH-1:0]                         o_data,
  output logic                                          o_legal
);

  assign o_opcode = i_instruction[OPCODE_WIDTH-1:0];
  assign o_addr   = i_instruction[OPCODE_WIDTH +: ADDR_WIDTH];
  assign o_data   = i_instruction[OPCODE_WIDTH+ADDR_WIDTH +: DATA_WIDTH];

  // Legal when the opcode matches one of the four implemented commands
  always_comb begin
    o_legal = (o_opcode == OPCODE_WIDTH'(OPCODE_NOP))      ||
              (o_opcode == OPCODE_WIDTH'(OPCODE_MEMWRITE)) ||
              (o_opcode == OPCODE_WIDTH'(OPCODE_MEMREAD))  ||
              (o_opcode == OPCODE_WIDTH'(OPCODE_MEMADD));
  end

endmodule

// File: rtl/datapath_executor.sv
// Responder side of the start/instruction/finished/result handshake.
// Executes one instruction at a time against a single-port synchronous RAM
// with one cycle of read latency.
module datapath_executor
  import datapath_executor_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                          clock,
  input  logic                                          resetn,
  input  logic                                          start,
  input  logic [DATA_WIDTH+ADDR_WIDTH+OPCODE_WIDTH-1:0] instruction,
  output logic                                          finished,
  output logic [DATA_WIDTH-1:0]                         result,
  output logic                                          error,
  output logic [ADDR_WIDTH-1:0]                         mem_addr,
  output logic [DATA_WIDTH-1:0]                         mem_wdata,
  output logic                                          mem_we,
  input  logic [DATA_WIDTH-1:0]                         mem_rdata
);

  localparam int INSTRUCTION_WIDTH = DATA_WIDTH + ADDR_WIDTH + OPCODE_WIDTH;

  // Sum written back by MEMADD wraps modulo 2^DATA_WIDTH
  function automatic logic [DATA_WIDTH-1:0] wrap_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic                    w_legal;
  logic                    w_accept;

  exec_state_t             r_state,    w_state_nxt;
  logic                    r_start_q;
  logic [DATA_WIDTH-1:0]   r_data,     w_data_nxt;
  logic                    r_illegal,  w_illegal_nxt;
  logic                    r_is_add,   w_is_add_nxt;
  logic                    r_finished, w_finished_nxt;
  logic [DATA_WIDTH-1:0]   r_result,   w_result_nxt;
  logic                    r_error,    w_error_nxt;
  logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata,    w_wdata_nxt;
  logic                    r_we,       w_we_nxt;

  instr_field_decode #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_decode (
    .i_instruction (instruction[INSTRUCTION_WIDTH-1:0]),
    .o_opcode      (w_opcode),
    .o_addr        (w_addr),
    .o_data        (w_data),
    .o_legal       (w_legal)
  );

  // Only a rising edge of start counts, so a held strobe never retriggers
  assign w_accept = start && !r_start_q;

  // Next-state and next-output decision for the executor FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_data_nxt     = r_data;
    w_illegal_nxt  = r_illegal;
    w_is_add_nxt   = r_is_add;
    w_finished_nxt = r_finished;
    w_result_nxt   = r_result;
    w_error_nxt    = r_error;
    w_mem_addr_nxt = r_mem_addr;
    w_wdata_nxt    = r_wdata;
    w_we_nxt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data_nxt     = w_data;
          w_illegal_nxt  = !w_legal;
          w_is_add_nxt   = (w_opcode == OPCODE_WIDTH'(OPCODE_MEMADD));
          w_finished_nxt = 1'b0;
          w_error_nxt    = 1'b0;
          if (w_opcode == OPCODE_WIDTH'(OPCODE_MEMWRITE)) begin
            w_mem_addr_nxt = w_addr;
            w_wdata_nxt    = w_data;
            w_we_nxt       = 1'b1;
            w_state_nxt    = ST_WRITE;
          end else if (w_opcode == OPCODE_WIDTH'(OPCODE_MEMREAD) ||
                       w_opcode == OPCODE_WIDTH'(OPCODE_MEMADD)) begin
            w_mem_addr_nxt = w_addr;
            w_state_nxt    = ST_READ_WAIT;
          end else begin
            w_state_nxt    = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        w_result_nxt   = r_data;
        w_finished_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_READ_WAIT: begin
        w_state_nxt = ST_READ_CAPTURE;
      end
      ST_READ_CAPTURE: begin
        if (r_is_add) begin
          w_wdata_nxt = wrap_add(mem_rdata, r_data);
          w_we_nxt    = 1'b1;
          w_state_nxt = ST_ADD_WRITE;
        end else begin
          w_result_nxt   = mem_rdata;
          w_finished_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_ADD_WRITE: begin
        w_result_nxt   = r_wdata;
        w_finished_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      ST_DONE: begin
        w_result_nxt   = '0;
        w_error_nxt    = r_illegal;
        w_finished_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_finished_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any command in flight
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_start_q  <= 1'b0;
      r_data     <= '0;
      r_illegal  <= 1'b0;
      r_is_add   <= 1'b0;
      r_finished <= 1'b1;
      r_result   <= '0;
      r_error    <= 1'b0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= start;
      r_data     <= w_data_nxt;
      r_illegal  <= w_illegal_nxt;
      r_is_add   <= w_is_add_nxt;
      r_finished <= w_finished_nxt;
      r_result   <= w_result_nxt;
      r_error    <= w_error_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_we       <= w_we_nxt;
    end
  end

  assign finished  = r_finished;
  assign result    = r_result;
  assign error     = r_error;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;

endmodule

// File: tb/tb_datapath_executor.sv
// Directed bench for datapath_executor with a behavioural synchronous RAM.
module tb_datapath_executor;
  import datapath_executor_pkg::*;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [27:0] instruction;
  logic        finished;
  logic [15:0] result;
  logic        error;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:255];
  int          we_count;
  int          we_run;
  int          we_max;
  logic [7:0]  last_wa;
  logic [15:0] last_wd;
  int          checks;
  int          passes;

  datapath_executor dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .instruction (instruction),
    .finished    (finished),
    .result      (result),
    .error       (error),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM, read data one cycle after address
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Write-pulse monitor: count pulses, remember last write, longest run
  always @(posedge clock) begin
    if (mem_we) begin
      we_count <= we_count + 1;
      last_wa  <= mem_addr;
      last_wd  <= mem_wdata;
      we_run   <= we_run + 1;
      if (we_run + 1 > we_max) we_max <= we_run + 1;
    end else begin
      we_run <= 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one command, hold start for 'hold' cycles, check latency and results
  task automatic do_cmd(input logic [27:0] instr, input int hold, input int exp_lat,
                        input int exp_we, input logic [15:0] exp_res,
                        input logic exp_err, input string tag);
    int lat;
    int c;
    int we0;
    we0 = we_count;
    @(negedge clock);
    start = 1'b1;
    instruction = instr;
    c = 0;
    @(negedge clock);
    c = 1;
    if (c >= hold) start = 1'b0;
    chk(finished, 1'b0, {tag, "_busy"});
    lat = 0;
    while (finished !== 1'b1 && lat < 10) begin
      @(negedge clock);
      lat++;
      c++;
      if (c >= hold) start = 1'b0;
    end
    chk(lat, exp_lat, {tag, "_latency"});
    chk(result, exp_res, {tag, "_result"});
    chk(error, exp_err, {tag, "_error"});
    while (c < hold) begin
      @(negedge clock);
      c++;
      chk(finished, 1'b1, {tag, "_hold_idle"});
    end
    start = 1'b0;
    @(negedge clock);
    chk(we_count - we0, exp_we, {tag, "_we_pulses"});
  endtask

  initial begin
    int we0;
    for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
    we_count = 0;
    we_run = 0;
    we_max = 0;
    last_wa = '0;
    last_wd = '0;
    checks = 0;
    passes = 0;
    resetn = 1'b0;
    start = 1'b0;
    instruction = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    chk(finished, 1'b1, "rst_finished");
    chk(result, 16'h0000, "rst_result");
    chk(error, 1'b0, "rst_error");
    chk(mem_we, 1'b0, "rst_mem_we");
    chk(mem_addr, 8'h00, "rst_mem_addr");
    chk(mem_wdata, 16'h0000, "rst_mem_wdata");

    repeat (10) @(negedge clock);
    chk(we_count, 0, "idle_no_we");
    chk(finished, 1'b1, "idle_finished");

    do_cmd(pack_instruction(OPCODE_MEMWRITE, 8'h05, 16'h1234), 2, 1, 1, 16'h1234, 1'b0, "wr5");
    chk(last_wa, 8'h05, "wr5_addr");
    chk(last_wd, 16'h1234, "wr5_data");

    do_cmd(pack_instruction(OPCODE_MEMREAD, 8'h05, 16'h0000), 2, 2, 0, 16'h1234, 1'b0, "rd5");

    do_cmd(pack_instruction(OPCODE_MEMADD, 8'h05, 16'hEDCD), 2, 3, 1, 16'h0001, 1'b0, "add5");
    chk(last_wa, 8'h05, "add5_addr");
    chk(last_wd, 16'h0001, "add5_data");
    do_cmd(pack_instruction(OPCODE_MEMREAD, 8'h05, 16'h0000), 2, 2, 0, 16'h0001, 1'b0, "rd5_after_add");

    do_cmd(pack_instruction(4'hF, 8'h05, 16'hFFFF), 2, 1, 0, 16'h0000, 1'b1, "illegal");
    do_cmd(pack_instruction(OPCODE_NOP, 8'h00, 16'h0000), 2, 1, 0, 16'h0000, 1'b0, "nop");

    do_cmd(pack_instruction(OPCODE_MEMWRITE, 8'hFF, 16'hBEEF), 8, 1, 1, 16'hBEEF, 1'b0, "wr_hold8");
    chk(last_wa, 8'hFF, "wr_hold8_addr");
    do_cmd(pack_instruction(OPCODE_NOP, 8'h00, 16'h0000), 2, 1, 0, 16'h0000, 1'b0, "nop_clear");

    do_cmd(pack_instruction(OPCODE_MEMWRITE, 8'h20, 16'h00AA), 2, 1, 1, 16'h00AA, 1'b0, "wr20");
    we0 = we_count;
    @(negedge clock);
    start = 1'b1;
    instruction = pack_instruction(OPCODE_MEMADD, 8'h20, 16'h0001);
    @(negedge clock);
    chk(finished, 1'b0, "rstmid_busy");
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    start = 1'b0;
    chk(finished, 1'b1, "rstmid_finished");
    chk(mem_we, 1'b0, "rstmid_mem_we");
    repeat (5) @(negedge clock);
    chk(we_count - we0, 0, "rstmid_no_write");
    do_cmd(pack_instruction(OPCODE_MEMREAD, 8'h20, 16'h0000), 2, 2, 0, 16'h00AA, 1'b0, "rd20");

    chk(we_max, 1, "we_single_cycle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
